// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Brief    : Configurable UART transmitter. Sends DBIT data bits LSB first,
//            framed by a start bit, an optional even/odd parity bit and one
//            or two stop bits. Bit timing is taken from an external
//            oversampling tick (s_tick).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DBIT       = 8,   // data bits per frame, 5..9
    parameter int OVERSAMPLE = 16,  // s_tick pulses per start/data/parity bit
    parameter int SB_TICK    = 16   // s_tick pulses per stop bit
) (
    input  logic            clk,
    input  logic            reset,        // asynchronous, active low
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    input  logic [1:0]      parity_mode,
    input  logic            two_stop,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            tx_busy
);

    // The tick counter is shared by every phase, so it must cover both the
    // longest data-type bit and a double-length stop phase.
    localparam int c_S_MAX = (OVERSAMPLE > 2*SB_TICK) ? OVERSAMPLE : 2*SB_TICK;
    localparam int c_S_W   = $clog2(c_S_MAX);
    localparam int c_N_W   = $clog2(DBIT);

    localparam logic [c_S_W-1:0] c_OS_LAST  = c_S_W'(OVERSAMPLE - 1);
    localparam logic [c_S_W-1:0] c_SB1_LAST = c_S_W'(SB_TICK - 1);
    localparam logic [c_S_W-1:0] c_SB2_LAST = c_S_W'(2*SB_TICK - 1);
    localparam logic [c_N_W-1:0] c_N_LAST   = c_N_W'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t             r_state,    w_state_next;
    logic [c_S_W-1:0]   r_s,        w_s_next;
    logic [c_N_W-1:0]   r_n,        w_n_next;
    logic [DBIT-1:0]    r_b,        w_b_next;
    logic               r_par,      w_par_next;
    logic               r_par_en,   w_par_en_next;
    logic               r_two_stop, w_two_stop_next;
    logic               r_tx,       w_tx_next;
    logic               w_done;
    logic [c_S_W-1:0]   w_stop_last;

    // State, counters, latched frame settings and the registered line output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_b        <= '0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_s        <= w_s_next;
            r_n        <= w_n_next;
            r_b        <= w_b_next;
            r_par      <= w_par_next;
            r_par_en   <= w_par_en_next;
            r_two_stop <= w_two_stop_next;
            r_tx       <= w_tx_next;
        end
    end

    assign w_stop_last = r_two_stop ? c_SB2_LAST : c_SB1_LAST;

    // Next-state, counter and shift-register logic; the line level is derived
    // from the next state so tx only moves on the edge that ends a bit.
    always_comb begin
        w_state_next    = r_state;
        w_s_next        = r_s;
        w_n_next        = r_n;
        w_b_next        = r_b;
        w_par_next      = r_par;
        w_par_en_next   = r_par_en;
        w_two_stop_next = r_two_stop;
        w_done          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Acceptance is immediate; it does not wait for a tick.
                if (tx_start) begin
                    w_state_next    = ST_START;
                    w_s_next        = '0;
                    w_n_next        = '0;
                    w_b_next        = din;
                    w_par_next      = (parity_mode == 2'b10) ? ~(^din) : (^din);
                    w_par_en_next   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    w_two_stop_next = two_stop;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == c_OS_LAST) begin
                        w_s_next     = '0;
                        w_state_next = ST_DATA;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == c_OS_LAST) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        w_n_next = r_n + c_N_W'(1);
                        if (r_n == c_N_LAST) begin
                            w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == c_OS_LAST) begin
                        w_s_next     = '0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // The done strobe is raised during the last stop tick so the
                // FIFO pop lands before the first IDLE cycle.
                if (s_tick) begin
                    if (r_s == w_stop_last) begin
                        w_s_next     = '0;
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_b_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_done_tick = w_done;
    assign tx_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Brief    : Directed self-checking bench for uart_tx_cfg (8-bit and 5-bit
//            builds) with hand-computed frame bit patterns and lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       s_tick = 1'b0;

    logic       rst8_n, start8, two8;
    logic [7:0] din8;
    logic [1:0] pm8;
    logic       tx8, done8, busy8;

    logic       rst5_n, start5, two5;
    logic [4:0] din5;
    logic [1:0] pm5;
    logic       tx5, done5, busy5;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) u_dut8 (
        .clk(clk), .reset(rst8_n), .s_tick(s_tick), .tx_start(start8),
        .din(din8), .parity_mode(pm8), .two_stop(two8),
        .tx(tx8), .tx_done_tick(done8), .tx_busy(busy8)
    );

    uart_tx_cfg #(.DBIT(5), .OVERSAMPLE(16), .SB_TICK(16)) u_dut5 (
        .clk(clk), .reset(rst5_n), .s_tick(s_tick), .tx_start(start5),
        .din(din5), .parity_mode(pm5), .two_stop(two5),
        .tx(tx5), .tx_done_tick(done5), .tx_busy(busy5)
    );

    // 100 MHz clock
    initial forever #5 clk = ~clk;

    // One-clk s_tick every 4 clocks, changed just after the rising edge
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clk);
            #1;
            tc++;
            s_tick = (tc % 4 == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one frame on the selected DUT (sel=1: 5-bit build) and checks the
    // sampled bit pattern (start, data, parity), stop level, length and strobe.
    task automatic send_frame(input bit sel, input logic [8:0] word, input logic [1:0] pm,
                              input logic two, input int nb, input logic [15:0] exp_vec,
                              input int total, input int abort_at, input int mangle_at,
                              input string tag);
        int k, cyc, done_k, dones;
        logic [15:0] vec;
        logic stop_ok;
        k = 0; cyc = 0; done_k = -1; dones = 0; vec = '0; stop_ok = 1'b1;
        @(negedge clk);
        if (sel) begin din5 = word[4:0]; pm5 = pm; two5 = two; start5 = 1'b1; end
        else     begin din8 = word[7:0]; pm8 = pm; two8 = two; start8 = 1'b1; end
        while (done_k < 0 && cyc < total*4 + 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq({tag, "_busy_on_accept"}, sel ? busy5 : busy8, 1);
                if (sel) start5 = 1'b0; else start8 = 1'b0;
            end
            if ((sel ? done5 : done8) && !s_tick) dones++;
            if (s_tick) begin
                k++;
                if (k % 16 == 8 && k / 16 < nb) vec[k/16] = sel ? tx5 : tx8;
                if (k > nb*16 && (sel ? tx5 : tx8) !== 1'b1) stop_ok = 1'b0;
                if (sel ? done5 : done8) begin dones++; done_k = k; end
                if (k == mangle_at) begin
                    if (sel) begin din5 = ~din5; pm5 = 2'b10; two5 = 1'b1; end
                    else     begin din8 = ~din8; pm8 = 2'b10; two8 = 1'b1; end
                end
                if (k == abort_at) begin
                    if (sel) rst5_n = 1'b0; else rst8_n = 1'b0;
                    #1;
                    check_eq({tag, "_abort_tx"},   sel ? tx5 : tx8, 1);
                    check_eq({tag, "_abort_busy"}, sel ? busy5 : busy8, 0);
                    dones = 0;
                    repeat (8) begin
                        @(negedge clk);
                        if (sel ? done5 : done8) dones++;
                    end
                    check_eq({tag, "_abort_no_done"}, dones, 0);
                    if (sel) rst5_n = 1'b1; else rst8_n = 1'b1;
                    return;
                end
            end
        end
        check_eq({tag, "_len_ticks"}, done_k, total);
        check_eq({tag, "_bits"}, vec, exp_vec);
        check_eq({tag, "_stop_high"}, stop_ok, 1);
        repeat (3) begin
            @(negedge clk);
            if (sel ? done5 : done8) dones++;
        end
        check_eq({tag, "_done_count"}, dones, 1);
        check_eq({tag, "_busy_after"}, sel ? busy5 : busy8, 0);
        check_eq({tag, "_tx_idle"}, sel ? tx5 : tx8, 1);
    endtask

    // Back-to-back frames with tx_start held high; din steps on each done.
    task automatic back_to_back();
        logic [7:0] words [3];
        logic [7:0] got;
        int k, cyc, extra;
        bit seen;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        @(negedge clk);
        din8 = words[0]; pm8 = 2'b00; two8 = 1'b0; start8 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            k = 0; cyc = 0; got = '0; seen = 1'b0;
            while (!seen && cyc < 800) begin
                @(negedge clk);
                cyc++;
                if (s_tick) begin
                    k++;
                    if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) got[k/16 - 1] = tx8;
                    if (done8) seen = 1'b1;
                end
            end
            check_eq($sformatf("b2b%0d_len_ticks", f), k, 160);
            check_eq($sformatf("b2b%0d_byte", f), got, words[f]);
            if (f < 2) din8 = words[f+1]; else start8 = 1'b0;
            @(negedge clk);
            check_eq($sformatf("b2b%0d_idle_gap", f), busy8, 0);
            @(negedge clk);
            check_eq($sformatf("b2b%0d_next_busy", f), busy8, (f < 2) ? 1 : 0);
            check_eq($sformatf("b2b%0d_next_tx", f), tx8, (f < 2) ? 0 : 1);
        end
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (done8) extra++;
        end
        check_eq("b2b_no_extra_done", extra, 0);
    endtask

    initial begin
        rst8_n = 1'b0; start8 = 1'b0; din8 = '0; pm8 = '0; two8 = 1'b0;
        rst5_n = 1'b0; start5 = 1'b0; din5 = '0; pm5 = '0; two5 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx8",   tx8,   1);
        check_eq("rst_busy8", busy8, 0);
        check_eq("rst_done8", done8, 0);
        check_eq("rst_tx5",   tx5,   1);
        check_eq("rst_busy5", busy5, 0);
        rst8_n = 1'b1; rst5_n = 1'b1;

        // Ticks while idle must not disturb the line
        repeat (20) @(negedge clk);
        check_eq("idle_tx8",   tx8,   1);
        check_eq("idle_busy8", busy8, 0);

        // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1 -> bit-vector 0x14A
        send_frame(0, 9'h0A5, 2'b00, 1'b0, 9,  16'h014A, 160, -1, -1, "t1_8n1");
        // Even parity of 0xA5 = 0, odd = 1
        send_frame(0, 9'h0A5, 2'b01, 1'b0, 10, 16'h014A, 176, -1, -1, "t2_even");
        send_frame(0, 9'h0A5, 2'b10, 1'b0, 10, 16'h034A, 176, -1, -1, "t2_odd");
        // 0x00, odd parity (1), two stop bits
        send_frame(0, 9'h000, 2'b10, 1'b1, 10, 16'h0200, 192, -1, -1, "t3_2stop");
        // Mode 11 behaves as no parity
        send_frame(0, 9'h0A5, 2'b11, 1'b0, 9,  16'h014A, 160, -1, -1, "t3_mode11");

        back_to_back();

        // Abort at tick 40, then a clean frame of 0x3C -> vector 0x78
        send_frame(0, 9'h0C3, 2'b00, 1'b0, 9,  16'h0000, 160, 40, -1, "t5_abort");
        send_frame(0, 9'h03C, 2'b00, 1'b0, 9,  16'h0078, 160, -1, -1, "t5_after");

        // 5-bit build: 0x1B, even parity 0: 0,1,1,0,1,1,0 -> 0x36; inputs
        // disturbed at tick 40 must not alter the frame
        send_frame(1, 9'h01B, 2'b01, 1'b0, 7,  16'h0036, 128, -1, 40, "t6_dbit5");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
